snake_judge: RTL and testbench

- Sits directly downstream of the snake movement stage. It consumes the packed body positions and the stop flag after each move tick.
- Per tick it checks wall stop, self-collision and food eaten, and updates the length fed back to the movement stage.
- When food is eaten it generates a new food cell that is not on the snake.
- It owns the game state, which display and score logic read.

---
 rtl/snake_pkg.sv | 42 ++++
 rtl/snake_lfsr.sv | 24 ++
 rtl/snake_judge.sv | 178 +++++++++++++++++
 tb/tb_snake_judge.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and constants for the snake pipeline stages.
// The slot-select helper is reused by the movement and display stages.
package snake_pkg;

  localparam int unsigned DefMaxLen       = 16;
  localparam int unsigned DefNumLen       = 10;
  localparam int unsigned DefWidth        = 32;
  localparam int unsigned DefHeight       = 24;
  localparam int unsigned DefMaxLenBitLen = 4;
  localparam int unsigned DefInitLen      = 3;
  localparam int unsigned DefFoodInit     = 100;

  localparam int unsigned GridCells = DefWidth * DefHeight;

  localparam int unsigned LfsrWidth = 10;
  localparam logic [LfsrWidth-1:0] LfsrSeed = 10'h2A5;
  // x^10 + x^7 + 1: feedback from bits 9 and 6
  localparam logic [LfsrWidth-1:0] LfsrTaps = 10'h240;

  typedef enum logic [1:0] {
    GameIdle = 2'b00,
    GameRun  = 2'b01,
    GameOver = 2'b10,
    GameWin  = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    StWait,
    StScan,
    StEat,
    StGen,
    StFin
  } judge_st_e;

  function automatic logic [DefNumLen-1:0] slot_sel(
    input logic [DefMaxLen*DefNumLen-1:0] vec,
    input logic [DefMaxLenBitLen-1:0]     idx
  );
    return vec[idx*DefNumLen +: DefNumLen];
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 10-bit Fibonacci LFSR; the non-zero seed keeps it out of the lock-up state.
module snake_lfsr
  import snake_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = LfsrSeed
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [LfsrWidth-1:0] value
);

  logic [LfsrWidth-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/snake_judge.sv
// Per-tick judge: wall stop, self-collision, food eaten, new food placement.
// Owns the game state, length and score consumed by movement, display and scoring.
module snake_judge
  import snake_pkg::*;
#(
  parameter int unsigned MaxLen       = DefMaxLen,
  parameter int unsigned NumLen       = DefNumLen,
  parameter int unsigned Width        = DefWidth,
  parameter int unsigned Height       = DefHeight,
  parameter int unsigned MaxLenBitLen = DefMaxLenBitLen,
  parameter int unsigned InitLen      = DefInitLen,
  parameter int unsigned FoodInit     = DefFoodInit
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step,
  input  logic                     should_stop,
  input  logic [MaxLen*NumLen-1:0] pos_num,
  output logic [MaxLenBitLen-1:0]  len,
  output logic [NumLen-1:0]        food_pos,
  output logic [7:0]               score,
  output logic [1:0]               state,
  output logic                     busy,
  output logic                     done
);

  localparam logic [NumLen:0]         GridLimit = (NumLen+1)'(Width * Height);
  localparam logic [MaxLenBitLen-1:0] LenOne    = MaxLenBitLen'(1);
  localparam logic [MaxLenBitLen-1:0] LenWin    = {MaxLenBitLen{1'b1}};
  localparam logic [MaxLenBitLen-1:0] LenInit   = MaxLenBitLen'(InitLen);
  localparam logic [NumLen-1:0]       FoodReset = NumLen'(FoodInit);

  judge_st_e                 st_q;
  game_state_e               state_q;
  logic [MaxLenBitLen-1:0]   len_q;
  logic [MaxLenBitLen-1:0]   idx_q;
  logic [NumLen-1:0]         food_q;
  logic [NumLen-1:0]         cand_q;
  logic                      cand_ok_q;
  logic [7:0]                score_q;
  logic                      busy_q;
  logic                      done_q;
  logic [NumLen-1:0]         snap_q [MaxLen];

  logic [LfsrWidth-1:0]      lfsr_value;
  logic [NumLen-1:0]         head;
  logic [NumLen-1:0]         idx_slot;
  logic [NumLen-1:0]         cand;
  logic                      cand_in_grid;
  logic [MaxLenBitLen-1:0]   len_last;
  logic [MaxLenBitLen-1:0]   len_inc;

  snake_lfsr #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .value(lfsr_value)
  );

  // A fresh candidate is taken straight from the LFSR; once it passes slot 0 it is held.
  assign head         = snap_q[0];
  assign idx_slot     = snap_q[idx_q];
  assign cand         = cand_ok_q ? cand_q : NumLen'(lfsr_value);
  assign cand_in_grid = {1'b0, cand} < GridLimit;
  assign len_last     = len_q - LenOne;
  assign len_inc      = len_q + LenOne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StWait;
      state_q   <= GameIdle;
      len_q     <= LenInit;
      idx_q     <= '0;
      food_q    <= FoodReset;
      cand_q    <= '0;
      cand_ok_q <= 1'b0;
      score_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < MaxLen; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (st_q)
        // FIN already shows busy=0, so it accepts start/step exactly like WAIT.
        StWait, StFin: begin
          st_q <= StWait;
          if (start) begin
            state_q <= GameRun;
            len_q   <= LenInit;
            score_q <= '0;
          end else if (step && state_q == GameRun) begin
            for (int unsigned i = 0; i < MaxLen; i++) begin
              snap_q[i] <= pos_num[i*NumLen +: NumLen];
            end
            idx_q <= LenOne;
            if (should_stop) begin
              st_q    <= StFin;
              state_q <= GameOver;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              st_q   <= (len_q > LenOne) ? StScan : StEat;
              busy_q <= 1'b1;
            end
          end
        end
        StScan: begin
          if (idx_slot == head) begin
            st_q    <= StFin;
            state_q <= GameOver;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (idx_q == len_last) begin
            st_q <= StEat;
          end else begin
            idx_q <= idx_q + LenOne;
          end
        end
        StEat: begin
          if (head == food_q) begin
            len_q   <= len_inc;
            score_q <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            if (len_inc == LenWin) begin
              st_q    <= StFin;
              state_q <= GameWin;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              st_q      <= StGen;
              idx_q     <= '0;
              cand_ok_q <= 1'b0;
            end
          end else begin
            st_q    <= StFin;
            state_q <= GameRun;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StGen: begin
          if (!cand_ok_q && !cand_in_grid) begin
            idx_q <= '0;
          end else if (idx_slot == cand) begin
            cand_ok_q <= 1'b0;
            idx_q     <= '0;
          end else if (idx_q == len_last) begin
            food_q    <= cand;
            cand_ok_q <= 1'b0;
            st_q      <= StFin;
            state_q   <= GameRun;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cand_q    <= cand;
            cand_ok_q <= 1'b1;
            idx_q     <= idx_q + LenOne;
          end
        end
        default: begin
          st_q   <= StWait;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign len      = len_q;
  assign food_pos = food_q;
  assign score    = score_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_snake_judge.sv
// Scoreboarded bench for snake_judge: directed scenarios followed by randomized games
// checked against a rule-level model of each tick.
module tb_snake_judge;

  localparam int ML       = 16;
  localparam int NL       = 10;
  localparam int Grid     = 768;
  localparam int InitLen  = 3;
  localparam int FoodInit = 100;
  localparam int WinLen   = 15;
  localparam int GIdle = 0, GRun = 1, GOver = 2, GWin = 3;

  typedef logic [ML-1:0][NL-1:0] slots_t;

  typedef struct packed {
    int     len;
    int     score;
    int     st;
    int     food_old;
    bit     ate;
    int     lat;
    int     step_cyc;
    slots_t slots;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               step;
  logic               should_stop;
  logic [ML*NL-1:0]   pos_num;
  logic [3:0]         len;
  logic [NL-1:0]      food_pos;
  logic [7:0]         score;
  logic [1:0]         state;
  logic               busy;
  logic               done;

  snake_judge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step       (step),
    .should_stop(should_stop),
    .pos_num    (pos_num),
    .len        (len),
    .food_pos   (food_pos),
    .score      (score),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int m_len, m_score, m_state, m_food;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pulse (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("state", int'(state), e.st);
        check("len", int'(len), e.len);
        check("score", int'(score), e.score);
        check("busy_at_done", int'(busy), 0);
        if (e.lat >= 0) check("latency", cyc - e.step_cyc, e.lat);
        if (e.ate && e.st != GWin) begin
          ok = (int'(food_pos) < Grid);
          for (int i = 0; i < e.len; i++) begin
            if (food_pos == e.slots[i]) ok = 1'b0;
          end
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL food_free: got food_pos=%0d want free cell below %0d", food_pos, Grid);
          end
        end else begin
          check("food_kept", int'(food_pos), e.food_old);
        end
      end
    end
  end

  function automatic slots_t rand_slots();
    slots_t s;
    for (int i = 0; i < ML; i++) s[i] = NL'($urandom_range(Grid - 1));
    return s;
  endfunction

  // Make body slots 1..n-1 differ from the head.
  function automatic slots_t declutter(input slots_t s, input int n);
    for (int i = 1; i < n; i++) begin
      if (s[i] == s[0]) s[i] = NL'((int'(s[i]) + 1) % Grid);
    end
    return s;
  endfunction

  task automatic issue_step(input slots_t sl, input bit stop, output bit ate);
    exp_t e;
    bit   coll;
    e     = '0;
    ate   = 1'b0;
    coll  = 1'b0;
    e.food_old = m_food;
    e.slots    = sl;
    if (stop) begin
      e.st  = GOver;
      e.lat = 1;
    end else begin
      for (int i = 1; i < m_len; i++) if (sl[i] == sl[0]) coll = 1'b1;
      if (coll) begin
        e.st  = GOver;
        e.lat = -1;
      end else if (int'(sl[0]) == m_food) begin
        ate     = 1'b1;
        m_len   = m_len + 1;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        e.st    = (m_len == WinLen) ? GWin : GRun;
        e.lat   = -1;
      end else begin
        e.st  = GRun;
        e.lat = m_len + 1;
      end
    end
    e.ate   = ate;
    e.len   = m_len;
    e.score = m_score;
    m_state = e.st;
    @(negedge clk);
    pos_num     = sl;
    should_stop = stop;
    step        = 1'b1;
    e.step_cyc  = cyc;
    sb.push_back(e);
    @(negedge clk);
    step        = 1'b0;
    should_stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending ticks want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic tick(input slots_t sl, input bit stop);
    bit ate;
    issue_step(sl, stop, ate);
    wait_idle(400);
    if (ate && m_state == GRun) m_food = int'(food_pos);
  endtask

  task automatic eat_tick();
    slots_t sl;
    sl    = rand_slots();
    sl[0] = NL'(m_food);
    tick(declutter(sl, m_len), 1'b0);
  endtask

  task automatic plain_slots(output slots_t sl);
    sl = rand_slots();
    if (int'(sl[0]) == m_food) sl[0] = NL'((m_food + 1) % Grid);
    sl = declutter(sl, m_len);
  endtask

  task automatic raw_step();
    @(negedge clk);
    pos_num = rand_slots();
    step    = 1'b1;
    @(negedge clk);
    step    = 1'b0;
  endtask

  task automatic do_start(input bit with_step);
    @(negedge clk);
    start = 1'b1;
    step  = with_step;
    @(negedge clk);
    start   = 1'b0;
    step    = 1'b0;
    m_state = GRun;
    m_len   = InitLen;
    m_score = 0;
    check("start_state", int'(state), GRun);
    check("start_len", int'(len), InitLen);
    check("start_score", int'(score), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    slots_t sl;
    bit     stop;
    int     r;
    bit     ate;
    rst_n = 1'b0; start = 1'b0; step = 1'b0; should_stop = 1'b0; pos_num = '0;
    m_len = InitLen; m_score = 0; m_state = GIdle; m_food = FoodInit;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", int'(state), GIdle);
    check("rst_len", int'(len), InitLen);
    check("rst_food", int'(food_pos), FoodInit);
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Step in IDLE is ignored.
    raw_step();
    repeat (5) @(negedge clk);
    check("idle_step_state", int'(state), GIdle);

    do_start(1'b0);
    sl = rand_slots(); sl[0] = 10'd5; sl[1] = 10'd4; sl[2] = 10'd3;
    tick(sl, 1'b0);
    sl = rand_slots(); sl[0] = 10'd100; sl[1] = 10'd99; sl[2] = 10'd98; sl[3] = 10'd300;
    tick(sl, 1'b0);
    eat_tick();
    sl = rand_slots();
    sl[0] = 10'd40; sl[1] = 10'd41; sl[2] = 10'd73; sl[3] = 10'd72; sl[4] = 10'd40;
    tick(sl, 1'b0);
    raw_step();
    repeat (10) @(negedge clk);
    check("over_step_ignored", int'(state), GOver);
    check("over_len_kept", int'(len), 5);
    do_start(1'b1);
    repeat (10) @(negedge clk);

    plain_slots(sl);
    tick(sl, 1'b1);

    // Reset in the third SCAN compare of a len=8 tick discards the tick.
    do_start(1'b0);
    repeat (5) eat_tick();
    plain_slots(sl);
    issue_step(sl, 1'b0, ate);
    @(negedge clk);
    @(negedge clk);
    check("scan_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", int'(state), GIdle);
    check("mid_rst_len", int'(len), InitLen);
    check("mid_rst_food", int'(food_pos), FoodInit);
    check("mid_rst_score", int'(score), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    sb.delete();
    m_len = InitLen; m_score = 0; m_state = GIdle; m_food = FoodInit;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // Directed win: twelve eats from length 3 reach 15.
    do_start(1'b0);
    while (m_state == GRun) eat_tick();
    check("win_state", int'(state), GWin);
    raw_step();
    repeat (5) @(negedge clk);

    for (int g = 0; g < 6; g++) begin
      do_start(1'b0);
      for (int t = 0; t < 40 && m_state == GRun; t++) begin
        r    = int'($urandom % 10);
        stop = 1'b0;
        sl   = rand_slots();
        if (r == 0) begin
          stop = 1'b1;
        end else if (r <= 2) begin
          sl[$urandom_range(m_len - 1, 1)] = sl[0];
        end else if (r <= 6) begin
          sl[0] = NL'(m_food);
          sl    = declutter(sl, m_len);
        end else begin
          plain_slots(sl);
        end
        tick(sl, stop);
      end
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
